sr_latch_ctrl: RTL and testbench



---
 rtl/sr_latch_ctrl.sv | 139 +++++++++++++
 tb/tb_sr_latch_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: round-robin arbiter sequencing set/reset pulses onto one SR latch; SR_SKIP_REDUNDANT_EN skips pulses the latch already satisfies
module sr_latch_ctrl #(
    parameter int NREQ        = 4,
    parameter int PULSE_CYC   = 2,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    input  logic            q,
    input  logic            q_bar,
    output logic            s,
    output logic            r,
    output logic [NREQ-1:0] gnt,
    output logic            done,
    output logic            err,
    output logic            busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = $clog2(PULSE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, PULSE, WAIT, DONE} state_t;
    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d, win, cand;
    logic            op_q, op_d, any_req, match;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [TW-1:0]   wcnt_q, wcnt_d;
    logic            s_q, s_d, r_q, r_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    assign s     = s_q;
    assign r     = r_q;
    assign gnt   = gnt_q;
    assign done  = done_q;
    assign err   = err_q;
    assign busy  = busy_q;
    // q == q_bar can never match since op_q and ~op_q always differ
    assign match = (q == op_q) && (q_bar == ~op_q);
    // round-robin pick: scan offsets high to low so the smallest offset from ptr wins
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (req[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end
    // next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        pcnt_d  = pcnt_q;
        wcnt_d  = wcnt_q;
        s_d     = s_q;
        r_d     = r_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (any_req) begin
                idx_d  = win;
                op_d   = op[win];
                gnt_d  = NREQ'(1) << win;
                busy_d = 1'b1;
`ifdef SR_SKIP_REDUNDANT_EN
                if ((q == op[win]) && (q_bar == ~op[win])) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else
`endif
                begin
                    state_d = PULSE;
                    pcnt_d  = PW'(1);
                    s_d     = op[win];
                    r_d     = ~op[win];
                end
            end
            PULSE: if (pcnt_q == PW'(PULSE_CYC)) begin
                state_d = WAIT;
                s_d     = 1'b0;
                r_d     = 1'b0;
                wcnt_d  = '0;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
            WAIT: if (match || (wcnt_q == TW'(TIMEOUT_CYC - 1))) begin
                state_d = DONE;
                done_d  = 1'b1;
                err_d   = ~match;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            op_q    <= 1'b0;
            pcnt_q  <= '0;
            wcnt_q  <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            pcnt_q  <= pcnt_d;
            wcnt_q  <= wcnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb_sr_latch_ctrl: directed checks of sr_latch_ctrl against a behavioural NOR latch (SR_SKIP_REDUNDANT_EN selects skip expectations)
module tb_sr_latch_ctrl;
    localparam int P = 2;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] op = '0;
    logic       q, q_bar, s, r, done, err, busy;
    logic [3:0] gnt;
    logic       lq = 1'b0;
    logic       force_en = 1'b0;
    logic       fq = 1'b0;
    logic       fqb = 1'b1;
    int         checks = 0;
    int         errors = 0;
    sr_latch_ctrl #(.NREQ(4), .PULSE_CYC(2), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .q(q), .q_bar(q_bar),
        .s(s), .r(r), .gnt(gnt), .done(done), .err(err), .busy(busy)
    );
    always #5 clk = ~clk;
    // NOR latch model, frozen while the readback is forced
    always @(s or r) begin
        if (!force_en) begin
            if (s && !r) lq = 1'b1;
            else if (r && !s) lq = 1'b0;
        end
    end
    assign q     = force_en ? fq : lq;
    assign q_bar = force_en ? fqb : ~lq;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) chk("sr_excl", 32'(s & r), 32'd0);
    // one transaction, sampled every cycle from the grant edge (k=0) to the cycle after done
    task automatic txn(input string tag, input logic [3:0] rq, input logic [3:0] o, input logic [3:0] eg,
                       input logic eop, input logic pls, input int edk, input logic eerr, input int drop);
        req = rq;
        op  = o;
        for (int k = 0; k <= edk + 1; k++) begin
            @(negedge clk);
            if (k <= edk) begin
                chk({tag, ":gnt"}, 32'(gnt), 32'(eg));
                chk({tag, ":busy"}, 32'(busy), 32'd1);
                chk({tag, ":s"}, 32'(s), 32'(pls && eop && k < P));
                chk({tag, ":r"}, 32'(r), 32'(pls && !eop && k < P));
                chk({tag, ":done"}, 32'(done), 32'(k == edk));
                if (k == edk) begin
                    chk({tag, ":err"}, 32'(err), 32'(eerr));
                    if (!force_en) chk({tag, ":q"}, 32'(q), 32'(eop));
                end
            end else begin
                chk({tag, ":done_end"}, 32'(done), 32'd0);
                chk({tag, ":busy_end"}, 32'(busy), 32'd0);
                chk({tag, ":gnt_end"}, 32'(gnt), 32'd0);
            end
            if (k == drop) req = '0;
        end
    endtask
    logic [3:0] rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       rr_o [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        txn("set", 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, P + 1, 1'b0, P + 1);
`ifdef SR_SKIP_REDUNDANT_EN
        txn("redund", 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0, 0, 1'b0, 0);
`else
        txn("redund", 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, P + 1, 1'b0, P + 1);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++)
            txn("rr", 4'b1111, 4'b1010, rr_g[i], rr_o[i], 1'b1, P + 1, 1'b0, (i == 4) ? P + 1 : -1);
        force_en = 1'b1;
        fq       = 1'b0;
        fqb      = 1'b1;
        txn("tmo", 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, P + 8, 1'b1, P + 8);
        force_en = 1'b0;
        req = 4'b1000;
        op  = 4'b1000;
        @(negedge clk);
        chk("midp_gnt", 32'(gnt), 32'b1000);
        chk("midp_s", 32'(s), 32'd1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("midp_rst_s", 32'(s), 32'd0);
        chk("midp_rst_r", 32'(r), 32'd0);
        chk("midp_rst_gnt", 32'(gnt), 32'd0);
        chk("midp_rst_busy", 32'(busy), 32'd0);
        chk("midp_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        txn("ptr0", 4'b1010, 4'b0000, 4'b0010, 1'b0, 1'b1, P + 1, 1'b0, P + 1);
        txn("idx3", 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1, P + 1, 1'b0, P + 1);
        txn("drop", 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, P + 1, 1'b0, P);
        txn("drop_ptr", 4'b1001, 4'b1000, 4'b1000, 1'b1, 1'b1, P + 1, 1'b0, P + 1);
        force_en = 1'b1;
        fq       = 1'b1;
        fqb      = 1'b1;
        txn("inval", 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, P + 8, 1'b1, P + 8);
        force_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
